control_fsm: RTL and testbench

CONTROL_FSM -- requirements
Module: control_fsm

---
 rtl/cpu_pkg.sv | 36 +++
 rtl/op_decode.sv | 28 ++
 rtl/control_fsm.sv | 192 +++++++++++++++++++
 tb/tb_control_fsm.sv | 291 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/cpu_pkg.sv
// Shared CPU control definitions: opcodes, instruction classes, FSM states,
// and the datapath select encodings driven by the control FSM.
package cpu_pkg;

  typedef enum logic [6:0] {
    OP_R      = 7'b0110011,
    OP_I      = 7'b0010011,
    OP_LOAD   = 7'b0000011,
    OP_STORE  = 7'b0100011,
    OP_BRANCH = 7'b1100011,
    OP_JAL    = 7'b1101111,
    OP_JALR   = 7'b1100111,
    OP_LUI    = 7'b0110111,
    OP_AUIPC  = 7'b0010111
  } opcode_e;

  typedef enum logic [3:0] {
    CL_R, CL_I, CL_LOAD, CL_STORE, CL_BRANCH,
    CL_JAL, CL_JALR, CL_LUI, CL_AUIPC, CL_ILLEGAL
  } op_class_e;

  typedef enum logic [2:0] {
    ST_FETCH, ST_DECODE, ST_EXEC, ST_MEM, ST_WB, ST_FAULT
  } state_e;

  typedef enum logic [1:0] {A_RS1 = 2'd0, A_OLD_PC = 2'd1, A_ZERO = 2'd2} alu_a_e;
  typedef enum logic [1:0] {B_RS2 = 2'd0, B_IMM = 2'd1, B_FOUR = 2'd2} alu_b_e;
  typedef enum logic [1:0] {ALU_ADD = 2'd0, ALU_BRANCH = 2'd1, ALU_FUNCT = 2'd2} alu_op_e;
  typedef enum logic [1:0] {WB_ALU = 2'd0, WB_MEM = 2'd1, WB_PC4 = 2'd2} wb_sel_e;
  typedef enum logic [1:0] {PC_PLUS4 = 2'd0, PC_TARGET = 2'd1, PC_TARGET_ALIGN = 2'd2} pc_src_e;

  localparam logic [1:0] CAUSE_NONE    = 2'd0;
  localparam logic [1:0] CAUSE_ILLEGAL = 2'd1;
  localparam logic [1:0] CAUSE_TIMEOUT = 2'd2;

endpackage

// File: rtl/op_decode.sv
// Combinational opcode classifier: maps ir[6:0] to an instruction class
// and flags opcodes the control path does not support.
module op_decode
  import cpu_pkg::*;
(
  input  logic [6:0] opcode,
  output op_class_e  op_class,
  output logic       legal
);

  always_comb begin
    op_class = CL_ILLEGAL;
    legal    = 1'b1;
    case (opcode)
      OP_R:      op_class = CL_R;
      OP_I:      op_class = CL_I;
      OP_LOAD:   op_class = CL_LOAD;
      OP_STORE:  op_class = CL_STORE;
      OP_BRANCH: op_class = CL_BRANCH;
      OP_JAL:    op_class = CL_JAL;
      OP_JALR:   op_class = CL_JALR;
      OP_LUI:    op_class = CL_LUI;
      OP_AUIPC:  op_class = CL_AUIPC;
      default:   legal    = 1'b0;
    endcase
  end

endmodule

// File: rtl/control_fsm.sv
// Multi-cycle CPU control FSM: FETCH/DECODE/EXEC/MEM/WB sequencing with a
// memory wait timeout and a sticky FAULT state.
module control_fsm
  import cpu_pkg::*;
#(
  parameter int unsigned MEM_TIMEOUT = 255
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] ir,
  input  logic        mem_ready,
  input  logic        branch_taken,
  output logic        mem_req,
  output logic        mem_we,
  output logic        mem_addr_sel,
  output logic        ir_we,
  output logic        pc_we,
  output logic        rf_we,
  output logic [1:0]  pc_src,
  output logic [1:0]  alu_a_sel,
  output logic [1:0]  alu_b_sel,
  output logic [1:0]  alu_op,
  output logic [1:0]  wb_sel,
  output logic        instr_retired,
  output logic        fault,
  output logic [1:0]  fault_cause
);

  localparam int unsigned CNT_W = $clog2(MEM_TIMEOUT + 1);

  state_e           state, state_nxt;
  op_class_e        cls, cls_q;
  logic             legal;
  logic [CNT_W-1:0] wait_cnt;
  logic [1:0]       cause_q, cause_nxt;
  logic             waiting;
  logic             timeout_hit;
  logic             unused_ir;

  assign unused_ir = ^ir[31:12];

  op_decode u_op_decode (
    .opcode   (ir[6:0]),
    .op_class (cls),
    .legal    (legal)
  );

  // Mem-ready arriving on the limit cycle takes priority over the timeout.
  assign waiting     = ((state == ST_FETCH) || (state == ST_MEM)) && !mem_ready;
  assign timeout_hit = waiting && (wait_cnt == CNT_W'(MEM_TIMEOUT - 1));

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= ST_FETCH;
      cls_q    <= CL_R;
      wait_cnt <= '0;
      cause_q  <= CAUSE_NONE;
    end else begin
      state    <= state_nxt;
      cause_q  <= cause_nxt;
      wait_cnt <= waiting ? wait_cnt + 1'b1 : '0;
      if (state == ST_DECODE) cls_q <= cls;
    end
  end

  always_comb begin
    state_nxt     = state;
    cause_nxt     = cause_q;
    mem_req       = 1'b0;
    mem_we        = 1'b0;
    mem_addr_sel  = 1'b0;
    ir_we         = 1'b0;
    pc_we         = 1'b0;
    rf_we         = 1'b0;
    instr_retired = 1'b0;
    fault         = 1'b0;
    pc_src        = PC_PLUS4;
    alu_a_sel     = A_RS1;
    alu_b_sel     = B_RS2;
    alu_op        = ALU_ADD;
    wb_sel        = WB_ALU;

    case (state)
      ST_FETCH: begin
        mem_req = 1'b1;
        if (mem_ready) begin
          ir_we     = 1'b1;
          pc_we     = 1'b1;
          pc_src    = PC_PLUS4;
          state_nxt = ST_DECODE;
        end else if (timeout_hit) begin
          state_nxt = ST_FAULT;
          cause_nxt = CAUSE_TIMEOUT;
        end
      end
      ST_DECODE: begin
        if (legal) begin
          state_nxt = ST_EXEC;
        end else begin
          state_nxt = ST_FAULT;
          cause_nxt = CAUSE_ILLEGAL;
        end
      end
      ST_EXEC: begin
        state_nxt = ST_WB;
        case (cls_q)
          CL_R:     alu_op = ALU_FUNCT;
          CL_I: begin
            alu_op    = ALU_FUNCT;
            alu_b_sel = B_IMM;
          end
          CL_LUI: begin
            alu_a_sel = A_ZERO;
            alu_b_sel = B_IMM;
          end
          CL_AUIPC: begin
            alu_a_sel = A_OLD_PC;
            alu_b_sel = B_IMM;
          end
          CL_LOAD, CL_STORE: begin
            alu_b_sel = B_IMM;
            state_nxt = ST_MEM;
          end
          CL_BRANCH: begin
            alu_op        = ALU_BRANCH;
            pc_we         = branch_taken;
            pc_src        = PC_TARGET;
            instr_retired = 1'b1;
            state_nxt     = ST_FETCH;
          end
          CL_JAL: begin
            alu_a_sel = A_OLD_PC;
            alu_b_sel = B_IMM;
            pc_we     = 1'b1;
            pc_src    = PC_TARGET;
          end
          CL_JALR: begin
            alu_b_sel = B_IMM;
            pc_we     = 1'b1;
            pc_src    = PC_TARGET_ALIGN;
          end
          default: begin
            state_nxt = ST_FAULT;
            cause_nxt = CAUSE_ILLEGAL;
          end
        endcase
      end
      ST_MEM: begin
        mem_req      = 1'b1;
        mem_addr_sel = 1'b1;
        mem_we       = (cls_q == CL_STORE);
        if (mem_ready) begin
          if (cls_q == CL_STORE) begin
            instr_retired = 1'b1;
            state_nxt     = ST_FETCH;
          end else begin
            wb_sel    = WB_MEM;
            state_nxt = ST_WB;
          end
        end else if (timeout_hit) begin
          state_nxt = ST_FAULT;
          cause_nxt = CAUSE_TIMEOUT;
        end
      end
      ST_WB: begin
        rf_we         = (ir[11:7] != 5'd0);
        instr_retired = 1'b1;
        state_nxt     = ST_FETCH;
        case (cls_q)
          CL_LOAD:         wb_sel = WB_MEM;
          CL_JAL, CL_JALR: wb_sel = WB_PC4;
          default:         wb_sel = WB_ALU;
        endcase
      end
      ST_FAULT: fault = 1'b1;
      default:  state_nxt = ST_FETCH;
    endcase

    // Reset silences every strobe in the same cycle, even mid-request.
    if (rst) begin
      mem_req       = 1'b0;
      mem_we        = 1'b0;
      ir_we         = 1'b0;
      pc_we         = 1'b0;
      rf_we         = 1'b0;
      instr_retired = 1'b0;
      fault         = 1'b0;
    end
    fault_cause = rst ? CAUSE_NONE : cause_q;
  end

endmodule

// File: tb/tb_control_fsm.sv
// Randomized bench for control_fsm: a per-instruction sequential model
// derives the expected outputs for every cycle of each instruction.
module tb_control_fsm;

  localparam int unsigned TMO = 4;

  localparam logic [6:0] O_R = 7'h33, O_I = 7'h13, O_LD = 7'h03, O_S = 7'h23, O_B = 7'h63;
  localparam logic [6:0] O_JAL = 7'h6F, O_JALR = 7'h67, O_LUI = 7'h37, O_AUIPC = 7'h17;
  localparam logic [1:0] SA_RS1 = 2'd0, SA_PC = 2'd1, SA_ZERO = 2'd2;
  localparam logic [1:0] SB_RS2 = 2'd0, SB_IMM = 2'd1;
  localparam logic [1:0] AO_ADD = 2'd0, AO_BR = 2'd1, AO_FN = 2'd2;
  localparam logic [1:0] W_ALU = 2'd0, W_MEM = 2'd1, W_PC4 = 2'd2;
  localparam logic [1:0] P_4 = 2'd0, P_T = 2'd1, P_TA = 2'd2;

  logic        clk = 1'b0;
  logic        rst, mem_ready, branch_taken;
  logic [31:0] ir;
  logic        mem_req, mem_we, mem_addr_sel, ir_we, pc_we, rf_we, instr_retired, fault;
  logic [1:0]  pc_src, alu_a_sel, alu_b_sel, alu_op, wb_sel, fault_cause;

  control_fsm #(.MEM_TIMEOUT(TMO)) dut (
    .clk(clk), .rst(rst), .ir(ir), .mem_ready(mem_ready), .branch_taken(branch_taken),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr_sel(mem_addr_sel),
    .ir_we(ir_we), .pc_we(pc_we), .rf_we(rf_we), .pc_src(pc_src),
    .alu_a_sel(alu_a_sel), .alu_b_sel(alu_b_sel), .alu_op(alu_op), .wb_sel(wb_sel),
    .instr_retired(instr_retired), .fault(fault), .fault_cause(fault_cause)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic mem_req, mem_we, mem_addr_sel, ir_we, pc_we, rf_we, instr_retired, fault;
    logic [1:0] pc_src, alu_a, alu_b, alu_op, wb_sel, cause;
  } obs_t;

  obs_t act;
  assign act = {mem_req, mem_we, mem_addr_sel, ir_we, pc_we, rf_we, instr_retired, fault,
                pc_src, alu_a_sel, alu_b_sel, alu_op, wb_sel, fault_cause};

  int         n_checks = 0;
  int         n_errors = 0;
  int         cyc;
  logic [1:0] cur_cause;

  function automatic obs_t base_mask();
    obs_t m = '0;
    m.mem_req = 1'b1; m.ir_we = 1'b1; m.pc_we = 1'b1; m.rf_we = 1'b1;
    m.instr_retired = 1'b1; m.fault = 1'b1; m.cause = 2'b11;
    return m;
  endfunction

  function automatic bit is_legal(input logic [6:0] o);
    return o inside {O_R, O_I, O_LD, O_S, O_B, O_JAL, O_JALR, O_LUI, O_AUIPC};
  endfunction

  task automatic compare(input string name, input obs_t e, input obs_t m);
    logic [$bits(obs_t)-1:0] d;
    d = (act ^ e) & m;
    n_checks++;
    if (d !== '0) begin
      n_errors++;
      $display("FAIL %s t=%0t ir=%h got=%h want=%h care=%h", name, $time, ir, act & m, e & m, m);
    end
  endtask

  task automatic chk_int(input string name, input int got, input int want);
    n_checks++;
    if (got != want) begin
      n_errors++;
      $display("FAIL %s got=%0d want=%0d", name, got, want);
    end
  endtask

  // Inputs are already applied; sample at the falling edge, then advance.
  task automatic step(input string name, input obs_t e, input obs_t m);
    #4;
    compare(name, e, m);
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    mem_ready = 1'($urandom);
    branch_taken = 1'($urandom);
    step("reset", '0, base_mask());
    rst = 1'b0;
    cur_cause = 2'd0;
  endtask

  task automatic hold_fault(input int n);
    obs_t e;
    for (int i = 0; i < n; i++) begin
      e = '0; e.fault = 1'b1; e.cause = cur_cause;
      mem_ready = 1'($urandom);
      branch_taken = 1'($urandom);
      step("fault_hold", e, base_mask());
    end
  endtask

  // Walk one instruction through its phases with wf/wm memory wait cycles.
  task automatic run_instr(input logic [31:0] instr, input int wf, input int wm, input bit bt,
                           output int ncyc, output int nmem, output int ret_cyc, output bit faulted);
    obs_t e, m;
    logic [6:0] opc;
    bit go_mem, go_wb;
    opc = instr[6:0];
    cyc = 0; nmem = 0; ret_cyc = 0; faulted = 1'b0; ncyc = 0;
    go_mem = 1'b0; go_wb = 1'b1;

    for (int k = 0; k <= wf; k++) begin
      e = '0; m = base_mask();
      mem_ready = (k == wf);
      branch_taken = 1'($urandom);
      e.mem_req = 1'b1; m.mem_we = 1'b1; m.mem_addr_sel = 1'b1;
      if (mem_ready) begin
        e.ir_we = 1'b1; e.pc_we = 1'b1; e.pc_src = P_4; m.pc_src = 2'b11;
      end
      step("fetch", e, m);
      if (!mem_ready && k == int'(TMO) - 1) begin
        cur_cause = 2'd2; faulted = 1'b1; ncyc = cyc; return;
      end
    end
    ir = instr;

    mem_ready = 1'($urandom);
    branch_taken = 1'($urandom);
    step("decode", '0, base_mask());
    if (!is_legal(opc)) begin
      cur_cause = 2'd1; faulted = 1'b1; ncyc = cyc; return;
    end

    e = '0; m = base_mask();
    mem_ready = 1'($urandom);
    branch_taken = bt;
    case (opc)
      O_R: begin e.alu_op = AO_FN; e.alu_b = SB_RS2; m.alu_op = '1; m.alu_b = '1; end
      O_I: begin e.alu_op = AO_FN; e.alu_b = SB_IMM; m.alu_op = '1; m.alu_b = '1; end
      O_LUI: begin e.alu_a = SA_ZERO; e.alu_b = SB_IMM; m.alu_a = '1; m.alu_b = '1; end
      O_AUIPC: begin e.alu_a = SA_PC; e.alu_b = SB_IMM; m.alu_a = '1; m.alu_b = '1; end
      O_LD, O_S: begin
        e.alu_op = AO_ADD; e.alu_a = SA_RS1; e.alu_b = SB_IMM;
        m.alu_op = '1; m.alu_a = '1; m.alu_b = '1;
        go_mem = 1'b1; go_wb = (opc == O_LD);
      end
      O_B: begin
        e.alu_op = AO_BR; m.alu_op = '1;
        e.instr_retired = 1'b1; e.pc_we = bt;
        if (bt) begin e.pc_src = P_T; m.pc_src = '1; end
        go_wb = 1'b0;
      end
      O_JAL: begin
        e.alu_a = SA_PC; e.alu_b = SB_IMM; e.alu_op = AO_ADD; e.pc_we = 1'b1; e.pc_src = P_T;
        m.alu_a = '1; m.alu_b = '1; m.alu_op = '1; m.pc_src = '1;
      end
      default: begin
        e.alu_a = SA_RS1; e.alu_b = SB_IMM; e.alu_op = AO_ADD; e.pc_we = 1'b1; e.pc_src = P_TA;
        m.alu_a = '1; m.alu_b = '1; m.alu_op = '1; m.pc_src = '1;
      end
    endcase
    step("exec", e, m);
    if (opc == O_B) ret_cyc = cyc;

    if (go_mem) begin
      for (int k = 0; k <= wm; k++) begin
        e = '0; m = base_mask();
        mem_ready = (k == wm);
        branch_taken = 1'($urandom);
        e.mem_req = 1'b1; e.mem_addr_sel = 1'b1; e.mem_we = (opc == O_S);
        m.mem_addr_sel = 1'b1; m.mem_we = 1'b1;
        if (mem_ready && opc == O_S) e.instr_retired = 1'b1;
        step("mem", e, m);
        nmem++;
        if (!mem_ready && k == int'(TMO) - 1) begin
          cur_cause = 2'd2; faulted = 1'b1; ncyc = cyc; return;
        end
      end
      if (opc == O_S) ret_cyc = cyc;
    end

    if (go_wb) begin
      e = '0; m = base_mask();
      mem_ready = 1'($urandom);
      branch_taken = 1'($urandom);
      e.rf_we = (instr[11:7] != 5'd0);
      e.instr_retired = 1'b1;
      e.wb_sel = (opc == O_LD) ? W_MEM : ((opc == O_JAL || opc == O_JALR) ? W_PC4 : W_ALU);
      m.wb_sel = '1;
      step("wb", e, m);
      ret_cyc = cyc;
    end
    ncyc = cyc;
  endtask

  initial begin : watchdog
    #2000000;
    $display("FAIL watchdog: time limit reached, checks=%0d", n_checks);
    $fatal(1, "time limit");
  end

  initial begin : main
    int ncyc, nmem, rc;
    bit flt;
    obs_t e, m;
    logic [6:0] opc;
    logic [31:0] instr;
    int wf, wm, pick;

    rst = 1'b1; mem_ready = 1'b0; branch_taken = 1'b0; ir = 32'h0; cur_cause = 2'd0;
    @(posedge clk);
    #1;
    do_reset();

    // addi x1,x0,5 with zero-wait memory
    run_instr(32'h00500093, 0, 0, 1'b0, ncyc, nmem, rc, flt);
    chk_int("addi_retire_cycle", rc, 4);

    // lw x3,4(x0) with three wait cycles in MEM
    run_instr(32'h00402183, 0, 3, 1'b0, ncyc, nmem, rc, flt);
    chk_int("lw_mem_req_cycles", nmem, 4);
    chk_int("lw_retire_cycle", rc, 8);

    // beq x0,x0,8 taken
    run_instr(32'h00000463, 0, 0, 1'b1, ncyc, nmem, rc, flt);
    chk_int("beq_retire_cycle", rc, 3);

    // all-zero word is illegal
    run_instr(32'h00000000, 0, 0, 1'b0, ncyc, nmem, rc, flt);
    chk_int("illegal_fault_flag", int'(flt), 1);
    chk_int("illegal_fault_cycle", ncyc, 2);
    hold_fault(5);
    do_reset();

    // fetch never answered: timeout after TMO wait cycles
    run_instr(32'h00500093, 20, 0, 1'b0, ncyc, nmem, rc, flt);
    chk_int("fetch_timeout_waits", ncyc, 4);
    hold_fault(4);
    do_reset();

    // ready arriving on the limit cycle wins
    run_instr(32'h00500093, int'(TMO) - 1, 0, 1'b0, ncyc, nmem, rc, flt);
    chk_int("limit_ready_no_fault", int'(flt), 0);
    chk_int("limit_ready_retire", rc, 7);

    // store stalls in MEM past the limit
    run_instr(32'h00112223, 0, 20, 1'b0, ncyc, nmem, rc, flt);
    chk_int("mem_timeout_cycle", ncyc, 7);
    hold_fault(2);
    do_reset();

    // reset lands while a load is waiting in MEM
    e = '0; m = base_mask(); mem_ready = 1'b1;
    e.mem_req = 1'b1; e.ir_we = 1'b1; e.pc_we = 1'b1;
    step("abort_fetch", e, m);
    ir = 32'h00402183; mem_ready = 1'b0;
    step("abort_decode", '0, base_mask());
    step("abort_exec", '0, base_mask());
    e = '0; e.mem_req = 1'b1;
    step("abort_mem", e, base_mask());
    do_reset();
    e = '0; m = base_mask(); e.mem_req = 1'b1; m.mem_we = 1'b1; m.mem_addr_sel = 1'b1;
    mem_ready = 1'b0;
    step("post_reset_fetch", e, m);
    do_reset();

    for (int n = 0; n < 300; n++) begin
      pick = int'($urandom_range(0, 9));
      case (pick)
        0: opc = O_R;    1: opc = O_I;    2: opc = O_LD;
        3: opc = O_S;    4: opc = O_B;    5: opc = O_JAL;
        6: opc = O_JALR; 7: opc = O_LUI;  8: opc = O_AUIPC;
        default: opc = 7'($urandom);
      endcase
      instr = $urandom;
      instr[6:0] = opc;
      if (pick == 1 && $urandom_range(0, 3) == 0) instr[11:7] = 5'd0;
      wf = ($urandom_range(0, 7) == 0) ? int'($urandom_range(0, TMO + 1)) : int'($urandom_range(0, 1));
      wm = ($urandom_range(0, 7) == 0) ? int'($urandom_range(0, TMO + 1)) : int'($urandom_range(0, 2));
      run_instr(instr, wf, wm, 1'($urandom), ncyc, nmem, rc, flt);
      if (flt) begin
        hold_fault(int'($urandom_range(1, 3)));
        do_reset();
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
